vball_gfx_rom_arb: RTL and testbench
====================================

# vball_gfx_rom_arb

Arbiter that shares the single graphics ROM read port between the background tile fetcher and the sprite line-buffer renderer. It accepts level-held requests from both engines, issues one ROM read at a time, and returns the 16-bit plane pair (two 8-bit planes) to the winning engine with a one-cycle acknowledge. Priority follows the video phase: background during active display, sprites during horizontal blank. A starvation guard and a read timeout keep either engine from stalling the frame.

## Interface

Parameters:

- TIMEOUT, 63: cycles in WAIT without `rom_valid` before the read is abandoned (1..255).
- MAX_SKIP, 3: consecutive lost arbitrations after which a pending requester wins regardless of phase (1..7).

Ports (clocking: one clock; reset is asynchronous and active-high):

- clk_sys  in  1  system clock; all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- hbl  in  1  horizontal blank; 1 selects sprite priority.
- bg_req  in  1  background request, level; held until `bg_ack`.
- bg_addr  in  17  background ROM address; stable while `bg_req` is high.
- bg_data  out  16  {plane2, plane1} for background; valid with `bg_ack`, held until the next `bg_ack`.
- bg_ack  out  1  one-cycle completion pulse.
- sp_req, sp_addr, sp_data, sp_ack: same as the `bg_*` ports, for the sprite engine.
- rom_addr  out  17  registered ROM address.
- rom_rd  out  1  one-cycle read strobe.
- rom_data  in  16  ROM read data.
- rom_valid  in  1  read data valid; variable latency, at least 1 cycle after `rom_rd`.
- timeout_err  out  1  sticky flag, set on any timeout, cleared only by reset.

## Operation

- States: IDLE, WAIT, ACK. All outputs are registered.
- **IDLE**
  - With no request, stay in IDLE.
  - With exactly one request, grant it.
  - With both requests, the preferred engine is sprite if `hbl`=1, otherwise background.
    - Exception: if the non-preferred engine's skip counter equals MAX_SKIP, the non-preferred engine wins.
  - On a grant:
    - Latch the winner's address into `rom_addr`.
    - Drive `rom_rd`=1 for one cycle.
    - Record the winner in `gnt` and go to WAIT.
- **Skip counters** (3 bits per engine):
  - Increment, saturating at MAX_SKIP, when the engine is requesting in IDLE and loses.
  - Clear to 0 when the engine is granted.
  - Unchanged otherwise.
- **WAIT**
  - `rom_valid` in the same cycle as `rom_rd` is ignored.
  - On the first later `rom_valid`:
    - Load `rom_data` into the granted engine's data register.
    - Assert its ack and go to ACK.
  - The wait counter (8 bits) increments every WAIT cycle.
  - If the count reaches TIMEOUT with no valid:
    - Load 16'h0000 into the granted engine's data register.
    - Assert its ack, set `timeout_err`, and go to ACK.
  - Valid and timeout in the same cycle: valid wins and the flag is not set.
- **ACK**
  - The ack is high for exactly this cycle; the wait counter clears.
  - Go to IDLE.
- **Requester rule:** the requester may deassert `req` on the edge after ack. A `req` still high in the cycle after ACK is a new request using the address present then.
- **Stale data:** `rom_valid` outside WAIT is ignored, including late data arriving after a timeout.
- **Reset** (any time, including mid-read):
  - State returns to IDLE.
  - `rom_rd`, both acks, `timeout_err`, skip counters and wait counter go to 0.
  - `rom_addr` goes to 0; `bg_data` and `sp_data` go to 16'h0000.
  - An outstanding ROM response arriving after reset is ignored.

## Timing

- Request sampled high in IDLE at cycle n:
  - `rom_rd`=1 and `rom_addr` valid in cycle n+1.
  - `rom_valid` at cycle k ≥ n+2 gives ack and data in cycle k+1.
  - IDLE resumes at k+2.
- Minimum turnaround with 1-cycle ROM latency is 4 cycles per read (n → n+4).
- Timeout: ack in cycle n+1+TIMEOUT+1 after the grant.
- Only one read is outstanding at any time; `rom_rd` never asserts outside the IDLE→WAIT transition.
- `hbl` and both requests are sampled only in IDLE; changes during WAIT/ACK do not affect the current grant.

## Test plan

- **Single background read:**
  - Stimulus: `bg_req`=1, `bg_addr`=17'h1A2B3; ROM returns 16'hC35A two cycles after `rom_rd`.
  - Response: `rom_rd` one cycle with `rom_addr`=17'h1A2B3; `bg_ack` one cycle with `bg_data`=16'hC35A; `sp_ack` stays 0.
- **Phase priority:**
  - Stimulus: both requests held, `hbl`=0, then `hbl`=1.
  - Response: background granted first with `hbl`=0; sprite granted first with `hbl`=1.
- **Starvation guard (MAX_SKIP=3):**
  - Stimulus: `hbl`=0, `bg_req` re-asserted continuously, `sp_req` held.
  - Response: background granted 3 times, then sprite granted on the 4th arbitration; sprite skip counter clears; next winner is background.
- **Timeout (TIMEOUT=63):**
  - Stimulus: sprite request; ROM never asserts `rom_valid`.
  - Response: `sp_ack` 64 cycles after `rom_rd`; `sp_data`=16'h0000; `timeout_err`=1 and stays 1.
  - Follow-up: a late `rom_valid` in IDLE changes nothing.
- **Back-to-back requests:**
  - Stimulus: `bg_req` held high across ack with the address changed on the ack edge from 17'h00010 to 17'h00011.
  - Response: the second `rom_rd` carries 17'h00011; no duplicate read of 17'h00010.
- **Reset mid-WAIT:**
  - Stimulus: assert `reset` during WAIT; ROM responds after reset is released.
  - Response: all outputs 0 immediately; no ack generated; arbiter returns to IDLE and serves the next request normally.

Source files
------------

// File: rtl/vball_gfx_rom_arb.sv
// vball_gfx_rom_arb
// Shares the single graphics ROM read port between the background tile
// fetcher and the sprite line-buffer renderer. One read is outstanding at a
// time; the winner gets its 16-bit plane pair back with a one-cycle ack.
// Background is preferred during active display and sprites during hblank.
// A per-engine skip counter stops either engine from being starved. A wait
// counter abandons reads the ROM never answers and raises a sticky error.

module vball_gfx_rom_arb #(
  parameter int unsigned TIMEOUT  = 63,
  parameter int unsigned MAX_SKIP = 3
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        hbl,
  input  logic        bg_req,
  input  logic [16:0] bg_addr,
  output logic [15:0] bg_data,
  output logic        bg_ack,
  input  logic        sp_req,
  input  logic [16:0] sp_addr,
  output logic [15:0] sp_data,
  output logic        sp_ack,
  output logic [16:0] rom_addr,
  output logic        rom_rd,
  input  logic [15:0] rom_data,
  input  logic        rom_valid,
  output logic        timeout_err
);

  localparam logic [7:0] TIMEOUT_C  = 8'(TIMEOUT);
  localparam logic [2:0] MAX_SKIP_C = 3'(MAX_SKIP);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  // gnt: 1'b0 = background owns the current read, 1'b1 = sprite.
  state_e      state_q,       state_d;
  logic        gnt_q,         gnt_d;
  logic [16:0] rom_addr_q,    rom_addr_d;
  logic        rom_rd_q,      rom_rd_d;
  logic [15:0] bg_data_q,     bg_data_d;
  logic [15:0] sp_data_q,     sp_data_d;
  logic        bg_ack_q,      bg_ack_d;
  logic        sp_ack_q,      sp_ack_d;
  logic        timeout_err_q, timeout_err_d;
  logic [2:0]  bg_skip_q,     bg_skip_d;
  logic [2:0]  sp_skip_q,     sp_skip_d;
  logic [7:0]  wait_cnt_q,    wait_cnt_d;

  logic        win_sp_s;

  // Saturating increment for the lost-arbitration counters.
  function automatic logic [2:0] skip_inc(input logic [2:0] cnt);
    logic [2:0] res;
    if (cnt >= MAX_SKIP_C) begin
      res = MAX_SKIP_C;
    end else begin
      res = cnt + 3'd1;
    end
    return res;
  endfunction

  // Pick the winner of an IDLE arbitration: phase preference, overridden
  // when the non-preferred engine has already lost MAX_SKIP times in a row.
  always_comb begin
    if (bg_req && sp_req) begin
      if (hbl) begin
        win_sp_s = (bg_skip_q != MAX_SKIP_C);
      end else begin
        win_sp_s = (sp_skip_q == MAX_SKIP_C);
      end
    end else begin
      win_sp_s = sp_req;
    end
  end

  // Next-state and next-output computation for the IDLE/WAIT/ACK sequencer.
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    rom_addr_d    = rom_addr_q;
    rom_rd_d      = 1'b0;
    bg_data_d     = bg_data_q;
    sp_data_d     = sp_data_q;
    bg_ack_d      = 1'b0;
    sp_ack_d      = 1'b0;
    timeout_err_d = timeout_err_q;
    bg_skip_d     = bg_skip_q;
    sp_skip_d     = sp_skip_q;
    wait_cnt_d    = wait_cnt_q;

    case (state_q)
      ST_IDLE: begin
        wait_cnt_d = 8'd0;
        if (bg_req || sp_req) begin
          gnt_d    = win_sp_s;
          rom_rd_d = 1'b1;
          state_d  = ST_WAIT;
          if (win_sp_s) begin
            rom_addr_d = sp_addr;
            sp_skip_d  = 3'd0;
            if (bg_req) begin
              bg_skip_d = skip_inc(bg_skip_q);
            end else begin
              bg_skip_d = bg_skip_q;
            end
          end else begin
            rom_addr_d = bg_addr;
            bg_skip_d  = 3'd0;
            if (sp_req) begin
              sp_skip_d = skip_inc(sp_skip_q);
            end else begin
              sp_skip_d = sp_skip_q;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q + 8'd1;
        // rom_rd_q marks the strobe cycle; a valid there cannot belong to
        // this read, so it is ignored. Valid beats timeout on a tie.
        if (rom_valid && !rom_rd_q) begin
          state_d = ST_ACK;
          if (gnt_q) begin
            sp_data_d = rom_data;
            sp_ack_d  = 1'b1;
          end else begin
            bg_data_d = rom_data;
            bg_ack_d  = 1'b1;
          end
        end else if (wait_cnt_q == TIMEOUT_C) begin
          state_d       = ST_ACK;
          timeout_err_d = 1'b1;
          if (gnt_q) begin
            sp_data_d = 16'h0000;
            sp_ack_d  = 1'b1;
          end else begin
            bg_data_d = 16'h0000;
            bg_ack_d  = 1'b1;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_ACK: begin
        wait_cnt_d = 8'd0;
        state_d    = ST_IDLE;
      end

      default: begin
        wait_cnt_d = 8'd0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any outstanding read.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      gnt_q         <= 1'b0;
      rom_addr_q    <= 17'h00000;
      rom_rd_q      <= 1'b0;
      bg_data_q     <= 16'h0000;
      sp_data_q     <= 16'h0000;
      bg_ack_q      <= 1'b0;
      sp_ack_q      <= 1'b0;
      timeout_err_q <= 1'b0;
      bg_skip_q     <= 3'd0;
      sp_skip_q     <= 3'd0;
      wait_cnt_q    <= 8'd0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      rom_addr_q    <= rom_addr_d;
      rom_rd_q      <= rom_rd_d;
      bg_data_q     <= bg_data_d;
      sp_data_q     <= sp_data_d;
      bg_ack_q      <= bg_ack_d;
      sp_ack_q      <= sp_ack_d;
      timeout_err_q <= timeout_err_d;
      bg_skip_q     <= bg_skip_d;
      sp_skip_q     <= sp_skip_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign rom_addr    = rom_addr_q;
  assign rom_rd      = rom_rd_q;
  assign bg_data     = bg_data_q;
  assign sp_data     = sp_data_q;
  assign bg_ack      = bg_ack_q;
  assign sp_ack      = sp_ack_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_vball_gfx_rom_arb.sv
// Self-checking bench for vball_gfx_rom_arb. Inputs are driven and outputs
// sampled on the falling clock edge. A transaction-level model (integer skip
// counts, expected data words, sticky timeout flag) predicts every grant.

module tb_vball_gfx_rom_arb;

  localparam int TO = 63;
  localparam int MS = 3;

  logic        clk_sys;
  logic        reset;
  logic        hbl;
  logic        bg_req;
  logic [16:0] bg_addr;
  logic [15:0] bg_data;
  logic        bg_ack;
  logic        sp_req;
  logic [16:0] sp_addr;
  logic [15:0] sp_data;
  logic        sp_ack;
  logic [16:0] rom_addr;
  logic        rom_rd;
  logic [15:0] rom_data;
  logic        rom_valid;
  logic        timeout_err;

  int n_checks = 0;
  int n_fail   = 0;
  int rd_cnt   = 0;

  // Reference model state
  int          m_bg_skip;
  int          m_sp_skip;
  logic        m_to;
  logic [15:0] m_bg_data;
  logic [15:0] m_sp_data;

  vball_gfx_rom_arb #(.TIMEOUT(TO), .MAX_SKIP(MS)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .hbl        (hbl),
    .bg_req     (bg_req),
    .bg_addr    (bg_addr),
    .bg_data    (bg_data),
    .bg_ack     (bg_ack),
    .sp_req     (sp_req),
    .sp_addr    (sp_addr),
    .sp_data    (sp_data),
    .sp_ack     (sp_ack),
    .rom_addr   (rom_addr),
    .rom_rd     (rom_rd),
    .rom_data   (rom_data),
    .rom_valid  (rom_valid),
    .timeout_err(timeout_err)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Count every ROM read strobe seen
  always @(negedge clk_sys) if (rom_rd === 1'b1) rd_cnt++;

  // Global time limit
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    m_bg_skip = 0;
    m_sp_skip = 0;
    m_to      = 1'b0;
    m_bg_data = 16'h0000;
    m_sp_data = 16'h0000;
  endfunction

  // Winner from the arbitration rules; updates the model skip counts
  function automatic logic model_pick(input logic b, input logic s, input logic h);
    logic w;
    if (b && !s) w = 1'b0;
    else if (!b && s) w = 1'b1;
    else if (h) w = (m_bg_skip == MS) ? 1'b0 : 1'b1;
    else w = (m_sp_skip == MS) ? 1'b1 : 1'b0;
    if (w) begin
      m_sp_skip = 0;
      if (b) m_bg_skip = (m_bg_skip + 1 > MS) ? MS : m_bg_skip + 1;
    end else begin
      m_bg_skip = 0;
      if (s) m_sp_skip = (m_sp_skip + 1 > MS) ? MS : m_sp_skip + 1;
    end
    return w;
  endfunction

  task automatic apply_reset();
    @(negedge clk_sys);
    reset = 1'b1; bg_req = 1'b0; sp_req = 1'b0; rom_valid = 1'b0; hbl = 1'b0;
    #1;
    n_checks++;
    if ({rom_rd, bg_ack, sp_ack, timeout_err, rom_addr, bg_data, sp_data} !== 52'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: rd=%b bga=%b spa=%b to=%b addr=%h bgd=%h spd=%h, all required 0",
               rom_rd, bg_ack, sp_ack, timeout_err, rom_addr, bg_data, sp_data);
    end
    @(negedge clk_sys);
    @(negedge clk_sys);
    reset = 1'b0;
    model_reset();
  endtask

  // One arbitration + read. Called at a falling edge of an IDLE cycle (t=0).
  // lat: rom_valid arrives lat cycles after the strobe; lat > TO means never.
  task automatic do_xfer(input logic b, input logic s, input logic h, input int lat,
                         input logic [16:0] ba, input logic [16:0] sa, input logic [15:0] d,
                         input logic hold, input logic [16:0] nba, output logic won_sp);
    logic        exp_sp;
    logic [16:0] ea;
    logic [15:0] ed;
    int          t_ack;
    bg_req = b; sp_req = s; hbl = h; bg_addr = ba; sp_addr = sa; rom_valid = 1'b0;
    exp_sp = model_pick(b, s, h);
    ea     = exp_sp ? sa : ba;
    t_ack  = (lat <= TO) ? lat + 2 : TO + 2;
    @(negedge clk_sys);  // t=1: strobe cycle
    n_checks++;
    if (rom_rd !== 1'b1 || rom_addr !== ea) begin
      n_fail++;
      $display("FAIL xfer_strobe: rom_rd=%b rom_addr=%h, required rd=1 addr=%h", rom_rd, rom_addr, ea);
    end
    rom_valid = 1'($urandom_range(0, 1));  // must be ignored
    rom_data  = ~d;
    for (int t = 2; t < t_ack; t++) begin
      @(negedge clk_sys);
      n_checks++;
      if (bg_ack !== 1'b0 || sp_ack !== 1'b0 || rom_rd !== 1'b0) begin
        n_fail++;
        $display("FAIL xfer_wait: t=%0d bg_ack=%b sp_ack=%b rom_rd=%b, required all 0", t, bg_ack, sp_ack, rom_rd);
      end
      rom_valid = (t == lat + 1);
      rom_data  = (t == lat + 1) ? d : 16'($urandom);
    end
    @(negedge clk_sys);  // ack cycle
    rom_valid = 1'b0;
    ed = (lat <= TO) ? d : 16'h0000;
    if (lat > TO) m_to = 1'b1;
    if (exp_sp) m_sp_data = ed; else m_bg_data = ed;
    won_sp = sp_ack;
    n_checks++;
    if (bg_ack !== !exp_sp || sp_ack !== exp_sp) begin
      n_fail++;
      $display("FAIL xfer_ack: bg_ack=%b sp_ack=%b, required bg_ack=%b sp_ack=%b", bg_ack, sp_ack, !exp_sp, exp_sp);
    end
    n_checks++;
    if (bg_data !== m_bg_data || sp_data !== m_sp_data) begin
      n_fail++;
      $display("FAIL xfer_data: bg_data=%h sp_data=%h, required %h %h", bg_data, sp_data, m_bg_data, m_sp_data);
    end
    n_checks++;
    if (timeout_err !== m_to) begin
      n_fail++;
      $display("FAIL xfer_timeout_err: timeout_err=%b, required %b", timeout_err, m_to);
    end
    if (hold) bg_addr = nba;
    else begin bg_req = 1'b0; sp_req = 1'b0; end
    @(negedge clk_sys);  // back in IDLE
    n_checks++;
    if (bg_ack !== 1'b0 || sp_ack !== 1'b0 || rom_rd !== 1'b0) begin
      n_fail++;
      $display("FAIL xfer_idle: bg_ack=%b sp_ack=%b rom_rd=%b, required all 0", bg_ack, sp_ack, rom_rd);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_sys);
      n_checks++;
      if (rom_rd !== 1'b0 || bg_ack !== 1'b0 || sp_ack !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle: rom_rd=%b bg_ack=%b sp_ack=%b, required 0", rom_rd, bg_ack, sp_ack);
      end
    end
  endtask

  task automatic test_single_bg();
    logic w;
    apply_reset();
    do_xfer(1'b1, 1'b0, 1'b0, 2, 17'h1A2B3, 17'h00000, 16'hC35A, 1'b0, 17'h0, w);
    n_checks++;
    if (w !== 1'b0 || bg_data !== 16'hC35A) begin
      n_fail++;
      $display("FAIL single_bg: sp_won=%b bg_data=%h, required 0 C35A", w, bg_data);
    end
  endtask

  task automatic test_phase_priority();
    logic w;
    apply_reset();
    do_xfer(1'b1, 1'b1, 1'b0, 1, 17'h00100, 17'h00200, 16'h1111, 1'b0, 17'h0, w);
    n_checks++;
    if (w !== 1'b0) begin n_fail++; $display("FAIL phase_hbl0: sp_won=%b, required 0", w); end
    do_xfer(1'b1, 1'b1, 1'b1, 1, 17'h00101, 17'h00201, 16'h2222, 1'b0, 17'h0, w);
    n_checks++;
    if (w !== 1'b1) begin n_fail++; $display("FAIL phase_hbl1: sp_won=%b, required 1", w); end
  endtask

  task automatic test_starvation();
    logic       w;
    logic [4:0] exp_seq;
    exp_seq = 5'b01000;  // index 0..4: bg bg bg sp bg
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      do_xfer(1'b1, 1'b1, 1'b0, $urandom_range(1, 3), 17'(i), 17'(17'h10000 + i),
              16'($urandom), 1'b0, 17'h0, w);
      n_checks++;
      if (w !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL starvation_%0d: sp_won=%b, required %b", i, w, exp_seq[i]);
      end
    end
  endtask

  task automatic test_timeout_boundary();
    logic w;
    apply_reset();
    do_xfer(1'b1, 1'b0, 1'b0, TO, 17'h0ABCD, 17'h0, 16'h5AA5, 1'b0, 17'h0, w);
    n_checks++;
    if (timeout_err !== 1'b0 || bg_data !== 16'h5AA5) begin
      n_fail++;
      $display("FAIL valid_at_limit: timeout_err=%b bg_data=%h, required 0 5AA5", timeout_err, bg_data);
    end
    do_xfer(1'b1, 1'b0, 1'b0, TO + 1, 17'h0ABCE, 17'h0, 16'h7777, 1'b0, 17'h0, w);
  endtask

  task automatic test_timeout();
    logic w;
    apply_reset();
    do_xfer(1'b0, 1'b1, 1'b1, 255, 17'h0, 17'h13579, 16'hFFFF, 1'b0, 17'h0, w);
    n_checks++;
    if (sp_data !== 16'h0000 || timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout: sp_data=%h timeout_err=%b, required 0000 1", sp_data, timeout_err);
    end
    rom_valid = 1'b1; rom_data = 16'h1234;  // late data while IDLE
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_sys);
      rom_valid = 1'b0;
      n_checks++;
      if (sp_ack !== 1'b0 || bg_ack !== 1'b0 || rom_rd !== 1'b0 || sp_data !== 16'h0000 || timeout_err !== 1'b1) begin
        n_fail++;
        $display("FAIL late_valid: sp_ack=%b bg_ack=%b rd=%b sp_data=%h to=%b, required 0 0 0 0000 1",
                 sp_ack, bg_ack, rom_rd, sp_data, timeout_err);
      end
    end
    do_xfer(1'b1, 1'b0, 1'b0, 1, 17'h00042, 17'h0, 16'h4242, 1'b0, 17'h0, w);
  endtask

  task automatic test_back_to_back();
    logic w;
    int   rd0;
    apply_reset();
    rd0 = rd_cnt;
    do_xfer(1'b1, 1'b0, 1'b0, 1, 17'h00010, 17'h0, 16'hAAAA, 1'b1, 17'h00011, w);
    do_xfer(1'b1, 1'b0, 1'b0, 1, 17'h00011, 17'h0, 16'hBBBB, 1'b0, 17'h0, w);
    n_checks++;
    if (rd_cnt - rd0 !== 2) begin
      n_fail++;
      $display("FAIL back_to_back_reads: %0d strobes, required 2", rd_cnt - rd0);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic w;
    @(negedge clk_sys);
    bg_req = 1'b1; sp_req = 1'b0; bg_addr = 17'h0F0F0; rom_valid = 1'b0;
    @(negedge clk_sys);
    n_checks++;
    if (rom_rd !== 1'b1) begin n_fail++; $display("FAIL midwait_strobe: rom_rd=%b, required 1", rom_rd); end
    @(negedge clk_sys);
    @(negedge clk_sys);
    apply_reset();
    rom_valid = 1'b1; rom_data = 16'hBEEF;  // stale response after reset
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_sys);
      rom_valid = 1'b0;
      n_checks++;
      if (bg_ack !== 1'b0 || sp_ack !== 1'b0 || rom_rd !== 1'b0 || bg_data !== 16'h0000) begin
        n_fail++;
        $display("FAIL midwait_after: bg_ack=%b sp_ack=%b rd=%b bg_data=%h, required 0 0 0 0000",
                 bg_ack, sp_ack, rom_rd, bg_data);
      end
    end
    do_xfer(1'b1, 1'b0, 1'b0, 2, 17'h00777, 17'h0, 16'h0777, 1'b0, 17'h0, w);
  endtask

  task automatic test_random();
    logic       w;
    logic [1:0] r;
    int         lat;
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      r   = 2'($urandom_range(1, 3));
      lat = ($urandom_range(0, 9) == 0) ? TO - 1 + $urandom_range(0, 2) : $urandom_range(1, 6);
      do_xfer(r[0], r[1], 1'($urandom_range(0, 1)), lat, 17'($urandom), 17'($urandom),
              16'($urandom), 1'b0, 17'h0, w);
    end
  endtask

  initial begin
    reset = 1'b1; hbl = 1'b0; bg_req = 1'b0; sp_req = 1'b0;
    bg_addr = 17'h0; sp_addr = 17'h0; rom_data = 16'h0; rom_valid = 1'b0;
    model_reset();
    test_reset();
    test_single_bg();
    test_phase_priority();
    test_starvation();
    test_timeout_boundary();
    test_timeout();
    test_back_to_back();
    test_reset_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
